// File: rtl/alu_issue_queue_if.sv
// Port bundle for alu_issue_queue: request intake, ALU issue, result delivery and status.
// Handshake: req and res transfer on a rising edge where valid && ready are both high; valid never waits on ready.
interface alu_issue_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
);
  logic                   i_req_valid;
  logic                   o_req_ready;
  logic [2:0]             i_req_op;
  logic [2:0]             i_req_ctrl;
  logic [DATA_W-1:0]      i_req_a;
  logic [DATA_W-1:0]      i_req_b;
  logic                   o_alu_valid;
  logic [2:0]             o_alu_op;
  logic [2:0]             o_alu_ctrl;
  logic [DATA_W-1:0]      o_alu_a;
  logic [DATA_W-1:0]      o_alu_b;
  logic                   i_alu_done;
  logic [DATA_W-1:0]      i_alu_data;
  logic                   i_alu_invalid;
  logic                   o_res_valid;
  logic                   i_res_ready;
  logic [DATA_W-1:0]      o_res_data;
  logic                   o_res_invalid;
  logic [$clog2(DEPTH):0] o_count;
  logic [CNT_W-1:0]       o_inv_cnt;
  logic [1:0]             o_state;

  modport master (
    input  i_req_valid, i_req_op, i_req_ctrl, i_req_a, i_req_b,
    input  i_alu_done, i_alu_data, i_alu_invalid, i_res_ready,
    output o_req_ready, o_alu_valid, o_alu_op, o_alu_ctrl, o_alu_a, o_alu_b,
    output o_res_valid, o_res_data, o_res_invalid, o_count, o_inv_cnt, o_state
  );

  modport slave (
    output i_req_valid, i_req_op, i_req_ctrl, i_req_a, i_req_b,
    output i_alu_done, i_alu_data, i_alu_invalid, i_res_ready,
    input  o_req_ready, o_alu_valid, o_alu_op, o_alu_ctrl, o_alu_a, o_alu_b,
    input  o_res_valid, o_res_data, o_res_invalid, o_count, o_inv_cnt, o_state
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Request FIFO plus a one-at-a-time issue sequencer in front of the multi-cycle ALU;
// results are held until accepted and invalid results are counted with saturation.
module alu_issue_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  alu_issue_queue_if.master q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 6 + 2 * DATA_W;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        op_q, ctrl_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_inv_q;
  logic [CNT_W-1:0]  inv_cnt_q;
  logic              push, pop, res_take, has_entry, capture;

  assign has_entry = (count_q != '0);
  assign q_if.o_req_ready = (count_q < FULL_C);
  assign push = q_if.i_req_valid && q_if.o_req_ready;
  assign res_take = (state_q == S_HOLD) && q_if.i_res_ready;
  // The head leaves the FIFO only on the edge that enters ISSUE.
  assign pop = has_entry && ((state_q == S_IDLE) || res_take);
  assign capture = (state_q == S_WAIT) && q_if.i_alu_done;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (has_entry) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (q_if.i_alu_done) state_d = S_HOLD;
      S_HOLD:  if (q_if.i_res_ready) state_d = has_entry ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {q_if.i_req_op, q_if.i_req_ctrl, q_if.i_req_a, q_if.i_req_b};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_q       <= '0;
      ctrl_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_inv_q  <= 1'b0;
      inv_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        {op_q, ctrl_q, a_q, b_q} <= mem_q[rd_ptr_q];
      end
      if (capture) begin
        res_data_q <= q_if.i_alu_data;
        res_inv_q  <= q_if.i_alu_invalid;
      end
      if (res_take && res_inv_q && !(&inv_cnt_q)) inv_cnt_q <= inv_cnt_q + 1'b1;
    end
  end

  assign q_if.o_alu_valid   = (state_q == S_ISSUE);
  assign q_if.o_alu_op      = op_q;
  assign q_if.o_alu_ctrl    = ctrl_q;
  assign q_if.o_alu_a       = a_q;
  assign q_if.o_alu_b       = b_q;
  assign q_if.o_res_valid   = (state_q == S_HOLD);
  assign q_if.o_res_data    = res_data_q;
  assign q_if.o_res_invalid = res_inv_q;
  assign q_if.o_count       = count_q;
  assign q_if.o_inv_cnt     = inv_cnt_q;
  assign q_if.o_state       = state_q;
endmodule
